// File: rtl/serial_alu_seq_if.sv
// Host/slice bundle for the bit-serial ALU sequencer.
// slave is the sequencer side; master is the host plus slice side.
interface serial_alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_m;
  logic [1:0]       op_s;
  logic             op_cin;
  logic             Ai;
  logic             Bi;
  logic             Ci;
  logic             S1;
  logic             S0;
  logic             M;
  logic             Cout;
  logic             Fi;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;

  modport slave (
    input  start, abort, op_a, op_b,
    input  op_m, op_s, op_cin,
    input  Cout, Fi,
    output Ai, Bi, Ci, S1, S0, M,
    output busy, done, result, carry_out
  );

  modport master (
    output start, abort, op_a, op_b,
    output op_m, op_s, op_cin,
    output Cout, Fi,
    input  Ai, Bi, Ci, S1, S0, M,
    input  busy, done, result, carry_out
  );
endinterface

// File: rtl/serial_alu_seq.sv
// Bit-serial sequencer driving one combinational 1-bit ALU slice,
// LSB first, with carry fed back from Cout to Ci between bits.
module serial_alu_seq #(
  parameter int WIDTH = 8
) (
  input logic            clk,
  input logic            rst,
  serial_alu_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic             ci_q, ci_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic [1:0]       s_q, s_d;
  logic             m_q, m_d;
  logic [WIDTH:0]   shifted;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      ci_q     <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      s_q      <= 2'b00;
      m_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      ci_q     <= ci_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      s_q      <= s_d;
      m_q      <= m_d;
    end
  end

  // Slice pins come straight from flops; the shifters and carry
  // are cleared on leaving RUN so Ai/Bi/Ci read 0 when idle.
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    ci_d     = ci_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    cout_d   = cout_q;
    s_d      = s_q;
    m_d      = m_q;
    shifted  = {bus.Fi, result_q} >> 1;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d  = RUN;
          a_sh_d   = bus.op_a;
          b_sh_d   = bus.op_b;
          ci_d     = bus.op_cin;
          cnt_d    = '0;
          result_d = '0;
          cout_d   = 1'b0;
          s_d      = bus.op_s;
          m_d      = bus.op_m;
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_d = IDLE;
          a_sh_d  = '0;
          b_sh_d  = '0;
          ci_d    = 1'b0;
        end else begin
          result_d = shifted[WIDTH-1:0];
          ci_d     = bus.Cout;
          a_sh_d   = a_sh_q >> 1;
          b_sh_d   = b_sh_q >> 1;
          cnt_d    = cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_d = DONE;
            cout_d  = m_q ? 1'b0 : bus.Cout;
            a_sh_d  = '0;
            b_sh_d  = '0;
            ci_d    = 1'b0;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.Ai        = a_sh_q[0];
  assign bus.Bi        = b_sh_q[0];
  assign bus.Ci        = ci_q;
  assign bus.S1        = s_q[1];
  assign bus.S0        = s_q[0];
  assign bus.M         = m_q;
  assign bus.busy      = (state_q == RUN);
  assign bus.done      = (state_q == DONE);
  assign bus.result    = result_q;
  assign bus.carry_out = cout_q;
endmodule
